// File: rtl/aes_cbc_pkg.sv
// Shared constants and the tag that travels alongside each block through the
// AES-128 CBC decrypt pipeline.
package aes_cbc_pkg;

  localparam int AES_BLOCK_W    = 128;
  localparam int PIPE_LAT_DEF   = 12;
  localparam int VEC_LAT_DEF    = 11;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int OUT_W          = AES_BLOCK_W + 1;

  typedef struct packed {
    logic                   valid;
    logic                   last;
    logic [AES_BLOCK_W-1:0] vec;
  } cbc_tag_t;

endpackage

// File: rtl/cbc_out_fifo.sv
// First-word-fall-through output FIFO; the head entry is visible whenever
// valid is high and reads as zero while empty.
module cbc_out_fifo
  import aes_cbc_pkg::*;
#(
  parameter int WIDTH = OUT_W,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && (count != FULL);

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage is deliberately not reset; emptiness is tracked by count
  // alone and the read port is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/aes_cbc_dec_ctrl.sv
// Flow controller for the free-running AES-128 CBC decrypt datapath: issues
// blocks, aligns the chaining vector, and buffers results under credit control.
module aes_cbc_dec_ctrl
  import aes_cbc_pkg::*;
#(
  parameter int PIPE_LAT   = PIPE_LAT_DEF,
  parameter int VEC_LAT    = VEC_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_ready,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [AES_BLOCK_W-1:0] s_data,
  input  logic                   s_first,
  input  logic                   s_last,
  input  logic [AES_BLOCK_W-1:0] iv,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [AES_BLOCK_W-1:0] m_data,
  output logic                   m_last,
  output logic                   busy,
  output logic [AES_BLOCK_W-1:0] dp_cipher_text,
  output logic [AES_BLOCK_W-1:0] dp_vector,
  input  logic [AES_BLOCK_W-1:0] dp_plain_text
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CREDITS = CNT_W'(FIFO_DEPTH);

  logic                   live_q;
  logic [CNT_W-1:0]       used_q;
  logic [AES_BLOCK_W-1:0] chain_q;
  cbc_tag_t               tag_q [PIPE_LAT];
  cbc_tag_t               tag_in;
  logic                   accept;
  logic                   out_fire;
  logic                   fifo_valid;
  logic [OUT_W-1:0]       fifo_out;

  // live_q keeps s_ready low while reset is held, even if key_ready is high.
  assign s_ready  = live_q && key_ready && (used_q < CREDITS);
  assign accept   = s_valid && s_ready;
  assign out_fire = fifo_valid && m_ready;
  assign busy     = (used_q != '0);

  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    tag_in = '0;
    if (accept) begin
      tag_in.valid = 1'b1;
      tag_in.last  = s_last;
      tag_in.vec   = s_first ? iv : chain_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  // Credits cover both in-flight blocks and FIFO occupancy, so a capture
  // from the non-stallable datapath always finds a free FIFO slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      used_q <= '0;
    end else begin
      unique case ({accept, out_fire})
        2'b10:   used_q <= used_q + 1'b1;
        2'b01:   used_q <= used_q - 1'b1;
        default: used_q <= used_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dp_cipher_text <= '0;
      chain_q        <= '0;
    end else if (accept) begin
      dp_cipher_text <= s_data;
      chain_q        <= s_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PIPE_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < PIPE_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Registered from stage VEC_LAT-1 so the vector lands VEC_LAT cycles
  // after the matching dp_cipher_text update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dp_vector <= '0;
    else        dp_vector <= tag_q[VEC_LAT-1].vec;
  end

  cbc_out_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tag_q[PIPE_LAT-1].valid),
    .push_data ({dp_plain_text, tag_q[PIPE_LAT-1].last}),
    .pop       (out_fire),
    .pop_data  (fifo_out),
    .valid     (fifo_valid)
  );

  assign m_valid = fifo_valid;
  assign m_data  = fifo_out[OUT_W-1:1];
  assign m_last  = fifo_out[0];

endmodule

// File: tb/tb_aes_cbc_dec_ctrl.sv
// Bench for aes_cbc_dec_ctrl with a behavioural AES-128 inverse-cipher
// datapath and a software CBC reference model.
module tb_aes_cbc_dec_ctrl;
  import aes_cbc_pkg::*;

  localparam int LAT       = PIPE_LAT_DEF + 1;
  localparam int DP_STAGES = PIPE_LAT_DEF - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         key_ready = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_first = 1'b0;
  logic         s_last = 1'b0;
  logic         m_ready = 1'b0;
  logic [127:0] s_data = '0;
  logic [127:0] iv = '0;
  logic         s_ready, m_valid, m_last, busy;
  logic [127:0] m_data, dp_cipher_text, dp_vector, dp_plain_text;

  aes_cbc_dec_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .key_ready      (key_ready),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_first        (s_first),
    .s_last         (s_last),
    .iv             (iv),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last),
    .busy           (busy),
    .dp_cipher_text (dp_cipher_text),
    .dp_vector      (dp_vector),
    .dp_plain_text  (dp_plain_text)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- AES-128 inverse cipher model ----------------
  logic [7:0]   sbox [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] rk [11];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xtime(a);
    end
    return p;
  endfunction

  task automatic build_aes(input logic [127:0] key);
    logic [7:0]  inv, s, rc;
    logic [31:0] w [44];
    logic [31:0] t;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x]     = s;
      inv_sbox[s] = 8'(x);
    end
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_dec(input logic [127:0] ct);
    logic [7:0]   st [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) st[i] = ct[127-8*i -: 8] ^ rk[10][127-8*i -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) t[4*c+rw] = st[4*((c-rw+4)%4)+rw];
      for (int i = 0; i < 16; i++) st[i] = inv_sbox[t[i]] ^ rk[rnd][127-8*i -: 8];
      if (rnd != 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
          st[4*c+1] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
          st[4*c+2] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
          st[4*c+3] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  // Free-running datapath: inverse cipher through DP_STAGES registers, then
  // the CBC XOR with dp_vector in the output cycle.
  logic [127:0] dp_pipe [DP_STAGES];
  always @(posedge clk) begin
    dp_pipe[0] <= aes_dec(dp_cipher_text);
    for (int i = 1; i < DP_STAGES; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign dp_plain_text = dp_pipe[DP_STAGES-1] ^ dp_vector;

  // ---------------- Monitor and reference model ----------------
  typedef struct { logic [127:0] data; logic last; int cyc; } out_t;
  typedef struct { logic [127:0] data; logic last; } exp_t;
  out_t         out_q [$];
  exp_t         exp_q [$];
  logic [127:0] vec_hist [int];
  logic [127:0] ct_hist [int];
  logic [127:0] model_chain = '0;
  bit           rand_mready = 1'b0;

  always @(negedge clk) begin
    vec_hist[cycle] = dp_vector;
    ct_hist[cycle]  = dp_cipher_text;
    if (m_valid && m_ready) out_q.push_back('{m_data, m_last, cycle});
  end

  always @(posedge clk) if (rand_mready) begin
    #1;
    m_ready = 1'($urandom_range(0, 1));
  end

  task automatic model_accept(input logic [127:0] ct, input logic first, input logic last,
                              input logic [127:0] ivv);
    logic [127:0] v;
    v = first ? ivv : model_chain;
    exp_q.push_back('{aes_dec(ct) ^ v, last});
    model_chain = ct;
  endtask

  // Entered just after a rising edge with s_valid already driven.
  task automatic wait_accept(output int acc_cyc);
    bit done = 1'b0;
    acc_cyc = -1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (s_ready) begin
        done = 1'b1;
        acc_cyc = cycle;
        model_accept(s_data, s_first, s_last, iv);
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) check_int("accept_timeout", 0, 1);
  endtask

  task automatic drive(input logic [127:0] ct, input logic first, input logic last,
                       input logic [127:0] ivv);
    s_valid = 1'b1; s_data = ct; s_first = first; s_last = last; iv = ivv;
  endtask

  task automatic send(input logic [127:0] ct, input logic first, input logic last,
                      input logic [127:0] ivv, output int acc_cyc);
    @(posedge clk); #1;
    drive(ct, first, last, ivv);
    wait_accept(acc_cyc);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_out(input int n, input int bound);
    for (int k = 0; k < bound && out_q.size() < n; k++) @(negedge clk);
    if (out_q.size() < n) check_int("output_timeout", out_q.size(), n);
  endtask

  task automatic compare_outputs(input string name);
    exp_t e;
    out_t o;
    int   i = 0;
    check_int({name, "_count"}, out_q.size(), exp_q.size());
    while (exp_q.size() != 0 && out_q.size() != 0) begin
      e = exp_q.pop_front();
      o = out_q.pop_front();
      check($sformatf("%s_data%0d", name, i), o.data, e.data);
      check_int($sformatf("%s_last%0d", name, i), int'(o.last), int'(e.last));
      i++;
    end
    exp_q.delete();
    out_q.delete();
  endtask

  task automatic reset_checks(input string p);
    check_int({p, "_s_ready"}, int'(s_ready), 0);
    check_int({p, "_m_valid"}, int'(m_valid), 0);
    check_int({p, "_m_last"}, int'(m_last), 0);
    check_int({p, "_busy"}, int'(busy), 0);
    check({p, "_m_data"}, m_data, '0);
    check({p, "_dp_cipher_text"}, dp_cipher_text, '0);
    check({p, "_dp_vector"}, dp_vector, '0);
  endtask

  typedef struct {
    logic [127:0] ct;
    logic         first;
    logic         last;
    logic [127:0] ivv;
    logic [127:0] exp_pt;
    logic         exp_last;
  } vec_t;

  vec_t         nist [4];
  int           acc [4];
  int           a, n, c, viol;
  out_t         o;
  logic [127:0] d0;

  initial begin
    build_aes(128'h2b7e151628aed2a6abf7158809cf4f3c);
    nist[0] = '{128'h7649abac8119b246cee98e9b12e9197d, 1'b1, 1'b0,
                128'h000102030405060708090a0b0c0d0e0f, 128'h6bc1bee22e409f96e93d7e117393172a, 1'b0};
    nist[1] = '{128'h5086cb9b507219ee95db113a917678b2, 1'b0, 1'b0,
                128'hffeeddccbbaa99887766554433221100, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b0};
    nist[2] = '{128'h73bed6b8e3c1743b7116e69e22229516, 1'b0, 1'b0,
                128'hffeeddccbbaa99887766554433221100, 128'h30c81c46a35ce411e5fbc1191a0a52ef, 1'b0};
    nist[3] = '{128'h3ff1caa1681fac09120eca307586e1a7, 1'b0, 1'b1,
                128'hffeeddccbbaa99887766554433221100, 128'hf69f2445df4f9b17ad2b417be66c3710, 1'b1};

    // Reset state, with key_ready already high.
    key_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("init");
    @(posedge clk); #1;
    reset = 1'b1;

    // NIST SP800-38A CBC-AES128 decrypt, back-to-back, m_ready high.
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(nist[i].ct, nist[i].first, nist[i].last, nist[i].ivv, acc[i]);
    idle();
    check_int("nist_back_to_back", acc[3] - acc[0], 3);
    wait_out(4, 40);
    for (int i = 0; i < 4 && out_q.size() != 0; i++) begin
      o = out_q.pop_front();
      check($sformatf("nist_pt%0d", i), o.data, nist[i].exp_pt);
      check_int($sformatf("nist_last%0d", i), int'(o.last), int'(nist[i].exp_last));
      check_int($sformatf("nist_latency%0d", i), o.cyc - acc[0], LAT + i);
    end
    exp_q.delete();
    out_q.delete();
    check("nist_dp_ct", ct_hist[acc[0] + 1], nist[0].ct);
    check("nist_dp_vec_iv", vec_hist[acc[0] + 1 + VEC_LAT_DEF], nist[0].ivv);
    check("nist_dp_vec_chain", vec_hist[acc[0] + 2 + VEC_LAT_DEF], nist[0].ct);
    @(negedge clk);
    check_int("nist_idle_busy", int'(busy), 0);

    // Two messages, second s_first directly after s_last.
    for (int i = 0; i < 6; i++)
      send({8'(i), 120'h5a5a_1234_5678_9abc_def0_0f1e_2d3c_4b}, (i == 0) || (i == 3),
           (i == 2) || (i == 5), (i < 3) ? 128'h11112222333344445555666677778888
                                         : 128'h99990000aaaabbbbccccddddeeeeffff, a);
    idle();
    wait_out(6, 60);
    compare_outputs("two_msg");

    // Backpressure: 20 blocks with m_ready low, only 16 credits.
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send({32'(i), 96'hc0ffee00_deadbeef_0badf00d}, i == 0, 1'b0,
           128'h0f0e0d0c0b0a09080706050403020100, acc[i % 2]);
      if (i == 0) a = acc[0];
    end
    check_int("bp_16_accepted", acc[1] - a, 15);
    @(posedge clk); #1;
    drive({32'd16, 96'hc0ffee00_deadbeef_0badf00d}, 1'b0, 1'b0, '0);
    viol = 0;
    repeat (30) begin
      @(negedge clk);
      if (s_ready) viol++;
      @(posedge clk); #1;
    end
    check_int("bp_no_accept_when_full", viol, 0);
    @(negedge clk);
    check_int("bp_busy", int'(busy), 1);
    check_int("bp_m_valid", int'(m_valid), 1);
    check("bp_head", m_data, exp_q[0].data);
    d0 = m_data;
    repeat (3) @(negedge clk);
    check("bp_head_stable", m_data, d0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    n = cycle;
    @(negedge clk);
    check_int("bp_pop_cycle_s_ready", int'(s_ready), 0);
    @(posedge clk); #1;
    wait_accept(a);
    check_int("bp_accept_after_pop", a - n, 1);
    for (int i = 17; i < 20; i++)
      send({32'(i), 96'hc0ffee00_deadbeef_0badf00d}, 1'b0, i == 19, '0, a);
    idle();
    wait_out(20, 200);
    compare_outputs("bp");

    // Simultaneous accept and pop with used = FIFO_DEPTH-1.
    m_ready = 1'b0;
    for (int i = 0; i < 15; i++)
      send({96'h1357_9bdf_2468_ace0_1111_2222, 32'(i)}, i == 0, 1'b0,
           128'hfedcba98765432100123456789abcdef, a);
    idle();
    repeat (16) @(posedge clk);
    @(negedge clk);
    check_int("simul_pre_s_ready", int'(s_ready), 1);
    check_int("simul_pre_m_valid", int'(m_valid), 1);
    @(posedge clk); #1;
    c = cycle;
    m_ready = 1'b1;
    drive({96'h1357_9bdf_2468_ace0_1111_2222, 32'd15}, 1'b0, 1'b0, '0);
    wait_accept(a);
    check_int("simul_accept_cycle", a - c, 0);
    @(posedge clk); #1;
    m_ready = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check_int("simul_s_ready_holds", int'(s_ready), 1);
    send({96'h1357_9bdf_2468_ace0_1111_2222, 32'd16}, 1'b0, 1'b1, '0, a);
    idle();
    @(negedge clk);
    check_int("simul_then_full", int'(s_ready), 0);
    m_ready = 1'b1;
    wait_out(17, 100);
    compare_outputs("simul");

    // Gapped input, random m_ready, key_ready dropped mid-stream.
    rand_mready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 2)) idle();
      if (i == 6) begin
        @(posedge clk); #1;
        drive({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, '0);
        key_ready = 1'b0;
        viol = 0;
        repeat (6) begin
          @(negedge clk);
          if (s_ready) viol++;
          @(posedge clk); #1;
        end
        key_ready = 1'b1;
        wait_accept(a);
        check_int("gap_key_ready_low", viol, 0);
      end else begin
        send({$urandom, $urandom, $urandom, $urandom}, i == 0, i == 11,
             128'h0123_4567_89ab_cdef_f0e1_d2c3_b4a5_9687, a);
      end
    end
    idle();
    rand_mready = 1'b0;
    @(posedge clk); #2;
    m_ready = 1'b1;
    wait_out(12, 300);
    compare_outputs("gap");

    // Reset with eight blocks in flight, then recovery.
    for (int i = 0; i < 8; i++)
      send({16'(i), 112'h7777_8888_9999_aaaa_bbbb_cccc_dddd}, i == 0, i == 7,
           128'h2222_3333_4444_5555_6666_7777_8888_9999, a);
    idle();
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    reset_checks("midrst");
    exp_q.delete();
    out_q.delete();
    model_chain = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (25) @(negedge clk);
    check_int("midrst_no_stale", out_q.size(), 0);
    send(128'h31415926_53589793_23846264_33832795, 1'b0, 1'b1,
         128'hffffffff_ffffffff_ffffffff_ffffffff, a);
    for (int i = 0; i < 3; i++)
      send({8'(i), 120'h2718_2818_2845_9045_2353_6028_7471_35}, i == 0, i == 2,
           128'h0a0b0c0d_0e0f1011_12131415_16171819, a);
    idle();
    wait_out(4, 60);
    compare_outputs("postrst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
